riscv_fetch: RTL and testbench

//  Instruction-fetch stage of riscv_pipeline: owns the PC, issues requests to instruction memory and

---
 rtl/riscv_fetch_pkg.sv | 14 +
 rtl/riscv_fetch_skid_buf.sv | 36 +++
 rtl/riscv_fetch.sv | 118 +++++++++++
 tb/tb_riscv_fetch.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, bus widths and the
// canonical NOP that IF/ID presents whenever it holds no live instruction.
package riscv_fetch_pkg;

  localparam int          DEFAULT_XLEN     = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/riscv_fetch_skid_buf.sv
// One-entry holding slot for a response that arrives while decode is stalled.
// Clear beats load, load beats drain.
module fetch_skid_buf
  import riscv_fetch_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load,
  input  logic            drain,
  input  logic            clear,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch: owns the PC, keeps one request outstanding to instruction
// memory and fills IF/ID, absorbing stalls via the skid slot and killing stale fetches on redirect.
module riscv_fetch
  import riscv_fetch_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc_plus4
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            kill_q;
  logic            fire;
  logic            resp;
  logic            deliver;
  logic            skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;
  logic [XLEN-1:0] redirect_target;

  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  assign fire            = imem_req && imem_gnt;
  assign resp            = (state_q == S_WAIT) && imem_rvalid;
  // A redirect in the same cycle as the response retires that request without delivering it.
  assign deliver         = resp && !kill_q && !redirect_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_REQ;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:   if (fire) state_d = S_WAIT;
      S_WAIT:  if (imem_rvalid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  // rstn gates the request so the bus sees it low throughout reset.
  always_comb begin
    imem_req  = rstn && (state_q == S_REQ) && !skid_valid;
    imem_addr = fetch_pc_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      kill_q     <= 1'b0;
    end else begin
      if (redirect_valid)  fetch_pc_q <= redirect_target;
      else if (fire)       fetch_pc_q <= fetch_pc_q + XLEN'(4);
      if (fire)            req_pc_q   <= fetch_pc_q;
      if (redirect_valid)  kill_q     <= ((state_q == S_WAIT) && !imem_rvalid) || fire;
      else if (resp)       kill_q     <= 1'b0;
    end
  end

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk        (clk),
    .rstn       (rstn),
    .load       (deliver && stall),
    .drain      (!stall),
    .clear      (redirect_valid),
    .load_pc    (req_pc_q),
    .load_instr (imem_rdata),
    .valid      (skid_valid),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  // IF/ID: redirect flushes, stall holds, otherwise skid content wins over a fresh response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      id_valid    <= 1'b0;
      id_pc       <= '0;
      id_instr    <= NOP_INSTR;
      id_pc_plus4 <= '0;
    end else if (redirect_valid) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
    end else if (!stall) begin
      if (skid_valid) begin
        id_valid    <= 1'b1;
        id_pc       <= skid_pc;
        id_instr    <= skid_instr;
        id_pc_plus4 <= skid_pc + XLEN'(4);
      end else if (deliver) begin
        id_valid    <= 1'b1;
        id_pc       <= req_pc_q;
        id_instr    <= imem_rdata;
        id_pc_plus4 <= req_pc_q + XLEN'(4);
      end else begin
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch: a scoreboard queue holds each instruction
// that should reach IF/ID, and every fresh IF/ID load is popped and compared.
module tb_riscv_fetch;
  import riscv_fetch_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  logic pre_stall;

  always #5 clk = ~clk;

  riscv_fetch u_dut (
    .clk            (clk),
    .rstn           (rstn),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_pc_plus4    (id_pc_plus4)
  );

  // The skid slot blocks new requests, so a response can never find it occupied.
  always @(negedge clk)
    if (rstn && imem_rvalid)
      assert (!u_dut.skid_valid) else $error("[TB] response arrived with skid occupied");

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one clock; a valid IF/ID after an unstalled edge is a fresh load.
  task automatic tick();
    exp_t e;
    pre_stall = stall;
    @(posedge clk);
    #1;
    if (rstn && id_valid && !pre_stall) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_id_valid", {31'b0, id_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("id_pc", id_pc, e.pc);
        checkOutput("id_instr", id_instr, e.instr);
        checkOutput("id_pc_plus4", id_pc_plus4, e.pc + 32'd4);
      end
    end
  endtask

  task automatic applyStimulus(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                               input logic stl, input logic redir, input logic [31:0] rpc);
    imem_gnt       = gnt;
    imem_rvalid    = rvalid;
    imem_rdata     = rdata;
    stall          = stl;
    redirect_valid = redir;
    redirect_pc    = rpc;
  endtask

  task automatic grantReq(input logic [31:0] exp_addr);
    int waited = 0;
    while (!imem_req && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("req_seen", {31'b0, imem_req}, 32'd1);
    checkOutput("req_addr", imem_addr, exp_addr);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
  endtask

  task automatic respond(input logic [31:0] instr, input logic [31:0] pc, input bit deliver);
    imem_rvalid = 1'b1;
    imem_rdata  = instr;
    if (deliver) sb.push_back('{pc, instr});
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (deliver && !stall) checkOutput("id_valid_latency", {31'b0, id_valid}, 32'd1);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    checkOutput({tag, "_id_valid"}, {31'b0, id_valid}, 32'd0);
    checkOutput({tag, "_id_pc"}, id_pc, 32'd0);
    checkOutput({tag, "_id_instr"}, id_instr, NOP_INSTR);
    checkOutput({tag, "_id_pc_plus4"}, id_pc_plus4, 32'd0);
  endtask

  initial begin
    rstn = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    checkReset("reset");
    rstn = 1'b1;
    #1;

    // Best-case latency from reset
    grantReq(32'h0);
    respond(32'h0050_0093, 32'h0, 1);
    grantReq(32'h4);
    respond(32'h0000_1111, 32'h4, 1);

    // Stall across a response: IF/ID holds, skid captures, requests pause
    stall = 1'b1;
    grantReq(32'h8);
    respond(32'h0000_2222, 32'h8, 1);
    checkOutput("stall_hold_pc", id_pc, 32'h4);
    checkOutput("stall_hold_valid", {31'b0, id_valid}, 32'd1);
    checkOutput("skid_blocks_req", {31'b0, imem_req}, 32'd0);
    tick();
    checkOutput("skid_blocks_req2", {31'b0, imem_req}, 32'd0);
    stall = 1'b0;
    tick();
    checkOutput("resume_req", {31'b0, imem_req}, 32'd1);
    checkOutput("resume_addr", imem_addr, 32'hC);

    // Redirect while waiting: stale response discarded, target word aligned
    grantReq(32'hC);
    respond(32'h0000_3333, 32'hC, 1);
    stall = 1'b1;
    grantReq(32'h10);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h103);
    tick();
    redirect_valid = 1'b0;
    checkOutput("redirect_flush", {31'b0, id_valid}, 32'd0);
    stall = 1'b0;
    respond(32'hBAD0_0001, 32'h10, 0);
    checkOutput("killed_resp", {31'b0, id_valid}, 32'd0);
    grantReq(32'h100);
    respond(32'h0000_4444, 32'h100, 1);

    // Redirect with stall and a full skid
    grantReq(32'h104);
    respond(32'h0000_5555, 32'h104, 1);
    stall = 1'b1;
    grantReq(32'h108);
    respond(32'hBAD0_0002, 32'h108, 0);
    checkOutput("skid_full_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h200);
    tick();
    redirect_valid = 1'b0;
    checkOutput("redir_stall_flush", {31'b0, id_valid}, 32'd0);
    checkOutput("redir_skid_cleared", {31'b0, imem_req}, 32'd1);
    checkOutput("redir_stall_addr", imem_addr, 32'h200);
    stall = 1'b0;
    tick();
    grantReq(32'h200);
    respond(32'h0000_6666, 32'h200, 1);

    // Grant withheld: request and address stay put
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_req", {31'b0, imem_req}, 32'd1);
      checkOutput("hold_addr", imem_addr, 32'h204);
      tick();
    end
    grantReq(32'h204);
    respond(32'h0000_7777, 32'h204, 1);

    // Redirect in S_REQ without grant, then PC wrap at the top of memory
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    tick();
    redirect_valid = 1'b0;
    checkOutput("wrap_target", imem_addr, 32'hFFFF_FFFC);
    grantReq(32'hFFFF_FFFC);
    checkOutput("wrap_addr", imem_addr, 32'h0);
    respond(32'h0000_8888, 32'hFFFF_FFFC, 1);

    // Redirect coinciding with the response: dropped, no lingering kill
    grantReq(32'h0);
    applyStimulus(1'b0, 1'b1, 32'hBAD0_0003, 1'b0, 1'b1, 32'h300);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("redir_rvalid_drop", {31'b0, id_valid}, 32'd0);
    grantReq(32'h300);
    respond(32'h0000_9999, 32'h300, 1);

    // Asynchronous reset while waiting; stale response afterwards ignored
    stall = 1'b1;
    grantReq(32'h304);
    checkOutput("pre_reset_valid", {31'b0, id_valid}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    checkReset("async_reset");
    stall = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'hBAD0_0004, 1'b0, 1'b0, '0);
    tick();
    imem_rvalid = 1'b0;
    checkOutput("stale_rvalid", {31'b0, id_valid}, 32'd0);
    grantReq(32'h0);
    respond(32'h0000_AAAA, 32'h0, 1);

    tick();
    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
